// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: joins the CPU's sram-like inst and data ports onto one AXI3 master.
// The bridge keeps one read (AR/R) and one write (AW/W/B) open at a time, and all bursts are single-beat.
// Data reads win over inst reads. Only one data transaction is open at a time, which makes loads RAW-safe.
module cpu_axi_bridge #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_sram_req,
    input  logic            inst_sram_wr,
    input  logic [1:0]      inst_sram_size,
    input  logic [3:0]      inst_sram_wstrb,
    input  logic [31:0]     inst_sram_addr,
    input  logic [31:0]     inst_sram_wdata,
    output logic            inst_sram_addr_ok,
    output logic            inst_sram_data_ok,
    output logic [31:0]     inst_sram_rdata,
    input  logic            data_sram_req,
    input  logic            data_sram_wr,
    input  logic [1:0]      data_sram_size,
    input  logic [3:0]      data_sram_wstrb,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic            data_sram_addr_ok,
    output logic            data_sram_data_ok,
    output logic [31:0]     data_sram_rdata,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);
    localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_WAIT = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2;

    logic [1:0] r_state, w_state;
    logic       data_busy, aw_done, w_done;
    logic       data_rd_acc, data_wr_acc, inst_rd_acc;
    logic       r_fire, b_fire, aw_hs, w_hs;

    // These inputs carry nothing the bridge needs (responses are not checked, and the inst port never writes).
    logic unused_inputs;
    assign unused_inputs = ^{rresp, rlast, bid, bresp, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata};

    // Single-beat incrementing bursts, normal access.
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'd0;
    assign awcache = 4'd0;
    assign arprot  = 3'd0;
    assign awprot  = 3'd0;
    assign awid    = ID_W'(1);
    assign wid     = ID_W'(1);
    assign wlast   = 1'b1;

    // Acceptance. A data read shadows any inst request in the same cycle.
    assign data_rd_acc = (r_state == R_IDLE) & data_sram_req & ~data_sram_wr & ~data_busy;
    assign data_wr_acc = (w_state == W_IDLE) & data_sram_req &  data_sram_wr & ~data_busy;
    assign inst_rd_acc = (r_state == R_IDLE) & inst_sram_req & ~data_rd_acc;
    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc | data_wr_acc;

    // Completion. rid selects which port gets the R beat. Only one data transaction is ever open,
    // so R and B cannot both complete a data request in the same cycle.
    assign r_fire = (r_state == R_WAIT) & rvalid;
    assign b_fire = (w_state == W_B) & bvalid;
    assign inst_sram_data_ok = r_fire & (rid == ID_W'(0));
    assign data_sram_data_ok = (r_fire & (rid != ID_W'(0))) | b_fire;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // Read FSM: capture the request, present it on AR, then wait for the single R beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (data_rd_acc) begin
                        arid    <= ID_W'(1);
                        araddr  <= data_sram_addr;
                        arsize  <= {1'b0, data_sram_size};
                        arvalid <= 1'b1;
                        r_state <= R_AR;
                    end else if (inst_rd_acc) begin
                        arid    <= ID_W'(0);
                        araddr  <= inst_sram_addr;
                        arsize  <= {1'b0, inst_sram_size};
                        arvalid <= 1'b1;
                        r_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: AW and W are raised together, each retires on its own handshake, then wait for B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_wr_acc) begin
                        awaddr  <= data_sram_addr;
                        awsize  <= {1'b0, data_sram_size};
                        wdata   <= data_sram_wdata;
                        wstrb   <= data_sram_wstrb;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        w_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        w_state <= W_B;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // A data request stays open from addr_ok to data_ok. No new data request is accepted meanwhile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_busy <= 1'b0;
        else if (data_rd_acc | data_wr_acc)
            data_busy <= 1'b1;
        else if (data_sram_data_ok)
            data_busy <= 1'b0;
    end
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge. The AXI slave is played by hand, step by step, from one initial block.
module tb_cpu_axi_bridge;
    localparam int ID_W = 4;

    logic            clk, reset;
    logic            inst_sram_req, inst_sram_wr;
    logic [1:0]      inst_sram_size;
    logic [3:0]      inst_sram_wstrb;
    logic [31:0]     inst_sram_addr, inst_sram_wdata;
    logic            inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0]     inst_sram_rdata;
    logic            data_sram_req, data_sram_wr;
    logic [1:0]      data_sram_size;
    logic [3:0]      data_sram_wstrb;
    logic [31:0]     data_sram_addr, data_sram_wdata;
    logic            data_sram_addr_ok, data_sram_data_ok;
    logic [31:0]     data_sram_rdata;
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0]     araddr, rdata, awaddr, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, arprot, awsize, awprot;
    logic [1:0]      arburst, arlock, rresp, awburst, awlock, bresp;
    logic [3:0]      arcache, awcache, wstrb;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_chk  = 0;
    int n_fail = 0;

    cpu_axi_bridge #(.ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later, well clear of the rising edge.
    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 1; bresp = 0; bvalid = 0;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_araddr", araddr, 0);
        chk("tie_off", {arlen, awlen, arburst, awburst, wlast}, {8'd0, 8'd0, 2'b01, 2'b01, 1'b1});

        // 1: inst read, arready after 2 cycles, rvalid 3 cycles later
        cyc; reset = 0;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2;
        #1 chk("t1_inst_addr_ok", inst_sram_addr_ok, 1);
        cyc; inst_sram_req = 0;
        #1 chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1c000000);
        chk("t1_arid", arid, 0);
        chk("t1_arsize", arsize, 2);
        cyc;
        #1 chk("t1_arvalid_held", arvalid, 1);
        arready = 1;
        cyc; arready = 0;
        #1 chk("t1_arvalid_drop", arvalid, 0);
        chk("t1_rready", rready, 1);
        cyc;
        cyc;
        #1 chk("t1_no_data_ok", inst_sram_data_ok, 0);
        cyc; rvalid = 1; rid = 0; rdata = 32'h02800c04;
        #1 chk("t1_inst_data_ok", inst_sram_data_ok, 1);
        chk("t1_inst_rdata", inst_sram_rdata, 32'h02800c04);
        chk("t1_data_data_ok", data_sram_data_ok, 0);
        cyc; rvalid = 0;
        #1 chk("t1_pulse_end", inst_sram_data_ok, 0);
        chk("t1_rready_drop", rready, 0);

        // 2: data read beats a same-cycle inst read
        inst_sram_req = 1; inst_sram_addr = 32'h1c000004;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h8000;
        #1 chk("t2_data_addr_ok", data_sram_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_sram_addr_ok, 0);
        cyc; data_sram_req = 0;
        #1 chk("t2_arid", arid, 1);
        chk("t2_araddr", araddr, 32'h8000);
        chk("t2_inst_blocked_ar", inst_sram_addr_ok, 0);
        arready = 1;
        cyc; arready = 0;
        #1 chk("t2_inst_blocked_wait", inst_sram_addr_ok, 0);
        rvalid = 1; rid = 1; rdata = 32'hcafebabe;
        #1 chk("t2_data_data_ok", data_sram_data_ok, 1);
        chk("t2_data_rdata", data_sram_rdata, 32'hcafebabe);
        chk("t2_inst_data_ok", inst_sram_data_ok, 0);
        chk("t2_inst_blocked_r", inst_sram_addr_ok, 0);
        cyc; rvalid = 0;
        #1 chk("t2_inst_accept", inst_sram_addr_ok, 1);
        cyc; inst_sram_req = 0;
        #1 chk("t2_inst_araddr", araddr, 32'h1c000004);
        chk("t2_inst_arid", arid, 0);
        arready = 1;
        cyc; arready = 0; rvalid = 1; rid = 0; rdata = 32'h00000001;
        #1 chk("t2_inst_data_ok2", inst_sram_data_ok, 1);
        cyc; rvalid = 0;

        // 3: write, wready two cycles before awready
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h8000;
        data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'b0011;
        #1 chk("t3_addr_ok", data_sram_addr_ok, 1);
        cyc; data_sram_req = 0;
        #1 chk("t3_aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("t3_awaddr", awaddr, 32'h8000);
        chk("t3_wdata", wdata, 32'h12345678);
        chk("t3_wstrb", wstrb, 4'b0011);
        chk("t3_awsize_ids", {awsize, awid, wid}, {3'd2, 4'd1, 4'd1});
        wready = 1;
        cyc; wready = 0;
        #1 chk("t3_w_first", {awvalid, wvalid}, 2'b10);
        cyc;
        #1 chk("t3_aw_held", {awvalid, bready}, 2'b10);
        awready = 1;
        cyc; awready = 0;
        #1 chk("t3_bready", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1;
        #1 chk("t3_data_ok", data_sram_data_ok, 1);
        cyc; bvalid = 0;
        #1 chk("t3_data_ok_end", data_sram_data_ok, 0);
        chk("t3_bready_drop", bready, 0);

        // 4: load behind an open store waits until the cycle after data_ok
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h8000;
        cyc; data_sram_wr = 0; data_sram_addr = 32'h8004;
        #1 chk("t4_load_blocked", data_sram_addr_ok, 0);
        awready = 1; wready = 1;
        cyc; awready = 0; wready = 0;
        #1 chk("t4_bready", bready, 1);
        chk("t4_load_blocked_b", data_sram_addr_ok, 0);
        bvalid = 1;
        #1 chk("t4_store_ok", data_sram_data_ok, 1);
        chk("t4_load_blocked_ok", data_sram_addr_ok, 0);
        cyc; bvalid = 0;
        #1 chk("t4_load_accept", data_sram_addr_ok, 1);
        cyc; data_sram_req = 0;
        #1 chk("t4_load_ar", {arid, araddr}, {4'd1, 32'h8004});
        arready = 1;
        cyc; arready = 0; rvalid = 1; rid = 1; rdata = 32'h55aa55aa;
        #1 chk("t4_load_ok", data_sram_data_ok, 1);
        cyc; rvalid = 0;

        // 5: inst read overlapping a write; B and R land in the same cycle
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h8010; data_sram_wdata = 32'hdeadbeef;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000008;
        #1 chk("t5_both_accept", {data_sram_addr_ok, inst_sram_addr_ok}, 2'b11);
        cyc; data_sram_req = 0; inst_sram_req = 0;
        #1 chk("t5_all_valid", {arvalid, awvalid, wvalid}, 3'b111);
        arready = 1; awready = 1; wready = 1;
        cyc; arready = 0; awready = 0; wready = 0;
        #1 chk("t5_readies", {rready, bready}, 2'b11);
        bvalid = 1; rvalid = 1; rid = 0; rdata = 32'h11112222;
        #1 chk("t5_both_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b11);
        chk("t5_inst_rdata", inst_sram_rdata, 32'h11112222);
        cyc; bvalid = 0; rvalid = 0;

        // 6: reset while the read sits in R_AR and the write in W_B
        data_sram_req = 1; data_sram_wr = 1; inst_sram_req = 1;
        cyc; data_sram_req = 0; inst_sram_req = 0;
        awready = 1; wready = 1;
        cyc; awready = 0; wready = 0;
        #1 chk("t6_pre", {arvalid, bready}, 2'b11);
        reset = 1;
        #1 chk("t6_reset_outs", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        cyc; reset = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h9000;
        #1 chk("t6_idle_accept", data_sram_addr_ok, 1);
        cyc; data_sram_req = 0;
        #1 chk("t6_new_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h9000});
        chk("t6_write_idle", {awvalid, wvalid, bready}, 3'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
